// File: rtl/sar_signed_search.sv
// Successive-approximation search for a signed target via an external (target < candidate) responder.
// One candidate per bit, MSB first; each bit costs one ISSUE and one WAIT cycle when the responder never stalls.
module sar_signed_search #(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                query_valid,
  input  logic                query_ready,
  output logic signed [N-1:0] query_value,
  input  logic                resp_valid,
  input  logic                resp_lt,
  output logic                done,
  output logic signed [N-1:0] result
);

  localparam int KW = (N > 2) ? $clog2(N) : 1;
  localparam logic [N-1:0]  ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  MSB   = {1'b1, {(N-1){1'b0}}};
  localparam logic [KW-1:0] K_TOP = KW'(N - 1);
  localparam logic [KW-1:0] K_ONE = KW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [N-1:0]  u, u_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [N-1:0]  qv_nxt, result_nxt;

  function automatic logic [N-1:0] bit_at(input logic [KW-1:0] idx);
    return ONE << idx;
  endfunction

  // u is kept in offset binary; flipping the MSB maps it back to two's complement.
  function automatic logic [N-1:0] cand(input logic [N-1:0] uu, input logic [KW-1:0] idx);
    logic [N-1:0] onehot;
    logic [N-1:0] keep;
    onehot = bit_at(idx);
    keep   = ~((onehot - ONE) | onehot);
    return ((uu & keep) | onehot) ^ MSB;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      u           <= '0;
      k           <= K_TOP;
      query_value <= '0;
      result      <= '0;
    end else begin
      state       <= state_nxt;
      u           <= u_nxt;
      k           <= k_nxt;
      query_value <= qv_nxt;
      result      <= result_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    u_nxt       = u;
    k_nxt       = k;
    qv_nxt      = query_value;
    result_nxt  = result;
    busy        = (state != IDLE);
    query_valid = (state == ISSUE);
    done        = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          u_nxt     = '0;
          k_nxt     = K_TOP;
          qv_nxt    = cand('0, K_TOP);
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (query_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (resp_valid) begin
          u_nxt = resp_lt ? (u & ~bit_at(k)) : (u | bit_at(k));
          if (k == '0) begin
            result_nxt = u_nxt ^ MSB;
            state_nxt  = DONE;
          end else begin
            k_nxt     = k - K_ONE;
            qv_nxt    = cand(u_nxt, k_nxt);
            state_nxt = ISSUE;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_signed_search.sv
// Directed bench for sar_signed_search (N=8) with a behavioural responder holding a hidden target.
module tb_sar_signed_search;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic query_ready = 1'b0;
  logic resp_valid = 1'b0;
  logic resp_lt = 1'b0;
  logic busy, query_valid, done;
  logic [N-1:0] query_value, result;

  int n_vec = 0;
  int n_err = 0;

  sar_signed_search #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .query_valid(query_valid), .query_ready(query_ready), .query_value(query_value),
    .resp_valid(resp_valid), .resp_lt(resp_lt), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic signed [7:0] tgt;
    logic [63:0]       qs;      // expected queries, first one in the top byte
    logic [7:0]        res;
    int                stall_max;
    int                dly_max;
    bit                noise;
    bit                chk_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_search(input logic signed [7:0] tgt, input int stall_max, input int dly_max,
                            input bit noise, input int abort_hs,
                            output logic [63:0] qs, output int nq, output logic [7:0] res,
                            output int done_cyc, output int ndone);
    int cyc, stall, cnt;
    bit pend, abort;
    logic [7:0] lastq, holdq;
    qs = '0; nq = 0; res = '0; done_cyc = -1; ndone = 0;
    cnt = 0; pend = 0; abort = 0; lastq = '0; holdq = '0;
    stall = $urandom_range(stall_max, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      resp_valid = 1'b0;
      resp_lt = 1'b0;
      start = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          resp_valid = 1'b1;
          resp_lt = (tgt < $signed(lastq));
        end
      end
      if (noise && query_valid && !resp_valid) begin
        resp_valid = 1'b1;
        resp_lt = 1'($urandom_range(1, 0));
      end
      if (noise && busy && !done) start = 1'($urandom_range(1, 0));
      if (noise && done) start = 1'b1;
      if (stall > 0 && query_valid) begin
        query_ready = 1'b0;
        stall--;
      end else begin
        query_ready = 1'b1;
      end
      if (query_valid && pend) chk("stall_stable", 64'(query_value), 64'(holdq));
      if (query_valid && query_ready) begin
        if (nq < 8) qs[63 - 8*nq -: 8] = query_value;
        nq++;
        lastq = query_value;
        cnt = $urandom_range(dly_max, 1);
        stall = $urandom_range(stall_max, 0);
        pend = 0;
        if (abort_hs > 0 && nq == abort_hs) abort = 1;
      end else if (query_valid) begin
        pend = 1;
        holdq = query_value;
      end else begin
        pend = 0;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          res = result;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) chk("idle_after_done", 64'(busy), 64'd0);
      @(posedge clk); #1;
      cyc++;
      if (abort) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_query_valid", 64'(query_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_query_value", 64'(query_value), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        break;
      end
      if (done_cyc >= 0 && cyc > done_cyc + 2) break;
    end
    resp_valid = 1'b0;
    resp_lt = 1'b0;
    start = 1'b0;
    query_ready = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    logic [63:0] qs;
    int nq, done_cyc, ndone, dseen;
    logic [7:0] res;

    vecs[0] = '{tgt: -8'sd37,  qs: 64'h00C0E0D0D8DCDADB, res: 8'hDB, stall_max: 0, dly_max: 1, noise: 0, chk_lat: 1};
    vecs[1] = '{tgt: 8'sd0,    qs: 64'h0040201008040201, res: 8'h00, stall_max: 0, dly_max: 1, noise: 1, chk_lat: 0};
    vecs[2] = '{tgt: -8'sd128, qs: 64'h00C0A09088848281, res: 8'h80, stall_max: 0, dly_max: 1, noise: 0, chk_lat: 1};
    vecs[3] = '{tgt: 8'sd127,  qs: 64'h004060707C7C7E7F, res: 8'h7F, stall_max: 0, dly_max: 1, noise: 0, chk_lat: 1};
    vecs[3].qs = 64'h00406070787C7E7F;
    vecs[4] = '{tgt: 8'sd5,    qs: 64'h0040201008040605, res: 8'h05, stall_max: 4, dly_max: 3, noise: 0, chk_lat: 0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_query_valid", 64'(query_valid), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_query_value", 64'(query_value), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    resp_valid = 1'b1;
    resp_lt = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    resp_lt = 1'b0;
    chk("idle_resp_ignored", 64'(busy), 64'd0);

    for (int v = 0; v < 5; v++) begin
      run_search(vecs[v].tgt, vecs[v].stall_max, vecs[v].dly_max, vecs[v].noise, 0,
                 qs, nq, res, done_cyc, ndone);
      for (int i = 0; i < 8; i++)
        chk($sformatf("v%0d_query%0d", v, i), 64'(qs[63 - 8*i -: 8]), 64'(vecs[v].qs[63 - 8*i -: 8]));
      chk($sformatf("v%0d_handshakes", v), 64'(nq), 64'd8);
      chk($sformatf("v%0d_done_pulses", v), 64'(ndone), 64'd1);
      chk($sformatf("v%0d_result", v), 64'(res), 64'(vecs[v].res));
      if (vecs[v].chk_lat) chk($sformatf("v%0d_latency", v), 64'(done_cyc), 64'd17);
      repeat (2) @(posedge clk);
      #1;
    end

    // Abort a search for target 10 just after its third handshake.
    run_search(8'sd10, 0, 1, 0, 3, qs, nq, res, done_cyc, ndone);
    chk("abort_handshakes", 64'(nq), 64'd3);
    dseen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) dseen++;
    end
    chk("abort_quiet_in_reset", 64'(dseen), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_search(-8'sd1, 0, 1, 0, 0, qs, nq, res, done_cyc, ndone);
    chk("m1_queries", qs, 64'h00C0E0F0F8FCFEFF);
    chk("m1_handshakes", 64'(nq), 64'd8);
    chk("m1_result", 64'(res), 64'hFF);
    chk("m1_latency", 64'(done_cyc), 64'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
